// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0800;
   localparam logic [WORD_W-1:0] HALT_WORD        = 32'h0000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small in-order instruction buffer; head is read straight from the entry registers.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     wrEntry,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);
   fetch_entry_t     entries [DEPTH];
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic             doPush, doPop;

   assign doPop  = pop && (count != '0);
   assign doPush = push && ((count != CNT_W'(DEPTH)) || doPop);
   assign head   = entries[rdPtr];

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            entries[wrPtr] <= wrEntry;
            wrPtr          <= wrPtr + 1'b1;
         end
         if (doPop) rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, halt detection, redirect/flush and the decode handshake.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic              CLOCK_50,
   input  logic              RESET_InHigh,
   output logic [WORD_W-1:0] BusDirecciones,
   input  logic [WORD_W-1:0] BusDatos,
   input  logic              Redirect_Valid,
   input  logic [WORD_W-1:0] Redirect_Target,
   output logic              Instr_Valid,
   input  logic              Instr_Ready,
   output logic [WORD_W-1:0] Instr_Data,
   output logic [WORD_W-1:0] Instr_PC,
   output logic              Halted
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [WORD_W-1:0] pc;
   logic              halted;
   logic              push, pop;
   logic [CNT_W-1:0]  count;
   fetch_entry_t      head, wrEntry;

   assign BusDirecciones = pc;
   assign Halted         = halted;
   assign Instr_Valid    = (count != '0);
   assign Instr_Data     = head.instr;
   assign Instr_PC       = head.pc;

   assign pop     = Instr_Valid && Instr_Ready;
   assign push    = !halted && !Redirect_Valid && ((count != CNT_W'(FIFO_DEPTH)) || pop);
   assign wrEntry = '{pc: pc, instr: BusDatos};

   // A captured halt word freezes the PC on its own address.
   always_ff @(posedge CLOCK_50) begin
      if (RESET_InHigh) begin
         pc     <= RESET_PC;
         halted <= 1'b0;
      end else if (Redirect_Valid) begin
         pc     <= Redirect_Target;
         halted <= 1'b0;
      end else if (push) begin
         if (BusDatos == HALT_WORD) halted <= 1'b1;
         else                       pc     <= pc + 1'b1;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
      .clk     (CLOCK_50),
      .rst     (RESET_InHigh),
      .push    (push),
      .pop     (pop),
      .flush   (Redirect_Valid),
      .wrEntry (wrEntry),
      .count   (count),
      .head    (head)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0800;

   logic        CLOCK_50 = 1'b0;
   logic        RESET_InHigh, Redirect_Valid, Instr_Ready;
   logic [31:0] Redirect_Target, BusDirecciones, BusDatos, Instr_Data, Instr_PC;
   logic        Instr_Valid, Halted;

   logic        rst2, rdy2, valid2, halted2;
   logic        rv2 = 1'b0;
   logic [31:0] tgt2 = 32'h0;
   logic [31:0] addr2, data2, idata2, ipc2;

   int nChecks = 0;
   int nErrors = 0;

   logic [63:0] mq[$];
   logic [31:0] mPc;
   bit          mHalt;

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [31:0] memImg(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'h800: memImg = 32'h8280_2001;
         32'h801: memImg = 32'h8480_2001;
         32'h802: memImg = 32'h8680_2000;
         32'h803: memImg = 32'h8880_2002;
         32'h804: memImg = 32'h8280_8003;
         32'h805: memImg = 32'h8480_8004;
         32'h806: memImg = 32'hA000_0005;
         32'h807: memImg = 32'hA200_0006;
         32'h808: memImg = 32'hC400_0007;
         32'h809: memImg = 32'hC600_0008;
         32'h80A: memImg = 32'hE000_0009;
         32'h80B: memImg = 32'hE200_000A;
         32'h80C: memImg = 32'h8080_000B;
         32'h80D: memImg = 32'h8280_000C;
         32'h80E: memImg = 32'h0000_0000;
         32'h80F: memImg = 32'h8480_000D;
         default: begin
            h = a * 32'h9E37_79B1 ^ 32'h5A5A_1234;
            memImg = (a[3:0] == 4'hE) ? 32'h0 : {1'b1, h[30:0]};
         end
      endcase
   endfunction

   assign BusDatos = memImg(BusDirecciones);
   assign data2    = memImg(addr2);

   fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .CLOCK_50        (CLOCK_50),
      .RESET_InHigh    (RESET_InHigh),
      .BusDirecciones  (BusDirecciones),
      .BusDatos        (BusDatos),
      .Redirect_Valid  (Redirect_Valid),
      .Redirect_Target (Redirect_Target),
      .Instr_Valid     (Instr_Valid),
      .Instr_Ready     (Instr_Ready),
      .Instr_Data      (Instr_Data),
      .Instr_PC        (Instr_PC),
      .Halted          (Halted)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .FIFO_DEPTH(4)) dutWrap (
      .CLOCK_50        (CLOCK_50),
      .RESET_InHigh    (rst2),
      .BusDirecciones  (addr2),
      .BusDatos        (data2),
      .Redirect_Valid  (rv2),
      .Redirect_Target (tgt2),
      .Instr_Valid     (valid2),
      .Instr_Ready     (rdy2),
      .Instr_Data      (idata2),
      .Instr_PC        (ipc2),
      .Halted          (halted2)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Behavioural view: a queue of {pc,word}, a fetch pointer and a halt flag.
   task automatic mdlEdge(input bit rst, input bit rv, input logic [31:0] tgt, input bit rdy);
      bit pop, push;
      if (rst) begin
         mq.delete(); mPc = RPC; mHalt = 0;
      end else if (rv) begin
         mq.delete(); mPc = tgt; mHalt = 0;
      end else begin
         pop  = rdy && (mq.size() > 0);
         push = !mHalt && ((mq.size() < DEPTH) || pop);
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back({mPc, memImg(mPc)});
            if (memImg(mPc) == 32'h0) mHalt = 1;
            else                      mPc   = mPc + 32'h1;
         end
      end
   endtask

   task automatic compareAll();
      chk("valid", Instr_Valid, mq.size() > 0);
      chk("addr", BusDirecciones, mPc);
      chk("halted", Halted, mHalt);
      if (mq.size() > 0) begin
         chk("headPc", Instr_PC, mq[0][63:32]);
         chk("headData", Instr_Data, mq[0][31:0]);
      end
   endtask

   task automatic tick(input bit rst, input bit rv, input logic [31:0] tgt, input bit rdy);
      RESET_InHigh    = rst;
      Redirect_Valid  = rv;
      Redirect_Target = tgt;
      Instr_Ready     = rdy;
      @(posedge CLOCK_50);
      mdlEdge(rst, rv, tgt, rdy);
      @(negedge CLOCK_50);
      compareAll();
   endtask

   initial begin
      logic [31:0] seqPc[3];
      logic [31:0] seqData[3];
      bit          rr, rv, rd;
      logic [31:0] tg;
      seqPc   = '{32'h800, 32'h801, 32'h802};
      seqData = '{32'h8280_2001, 32'h8480_2001, 32'h8680_2000};
      mPc = RPC; mHalt = 0;
      rst2 = 1'b1; rdy2 = 1'b1;

      // Reset state
      tick(1, 0, 0, 1);
      tick(1, 0, 0, 1);
      chk("rstValid", Instr_Valid, 0);
      chk("rstData", Instr_Data, 0);
      chk("rstPc", Instr_PC, 0);
      chk("rstAddr", BusDirecciones, 32'h800);
      chk("rstHalted", Halted, 0);

      // Reset sequence with ready held high
      for (int k = 0; k < 3; k++) begin
         tick(0, 0, 0, 1);
         chk("seqPc", Instr_PC, seqPc[k]);
         chk("seqData", Instr_Data, seqData[k]);
      end

      // Run into the halt word at 0x80E
      for (int k = 0; k < 30; k++) begin
         if (Instr_Valid && Instr_PC == 32'h80E) break;
         tick(0, 0, 0, 1);
      end
      chk("haltWordPc", Instr_PC, 32'h80E);
      chk("haltWordData", Instr_Data, 32'h0);
      chk("haltWordValid", Instr_Valid, 1);
      for (int k = 0; k < 4; k++) begin
         tick(0, 0, 0, 1);
         chk("haltFlag", Halted, 1);
         chk("haltAddr", BusDirecciones, 32'h80E);
         chk("haltNoValid", Instr_Valid, 0);
      end

      // Redirect while halted
      tick(0, 1, 32'h800, 1);
      chk("rdHaltClr", Halted, 0);
      chk("rdHaltAddr", BusDirecciones, 32'h800);
      chk("rdHaltBubble", Instr_Valid, 0);
      tick(0, 0, 0, 1);
      chk("rdHaltPc", Instr_PC, 32'h800);
      chk("rdHaltData", Instr_Data, 32'h8280_2001);

      // Backpressure after reset
      tick(1, 0, 0, 0);
      for (int k = 0; k < 5; k++) tick(0, 0, 0, 0);
      chk("bpAddr", BusDirecciones, 32'h802);
      chk("bpHeadData", Instr_Data, 32'h8280_2001);
      for (int k = 0; k < 3; k++) begin
         chk("bpOrder", Instr_PC, 32'h800 + k);
         tick(0, 0, 0, 1);
      end

      // Redirect with a full FIFO
      tick(0, 0, 0, 0);
      tick(0, 1, 32'h804, 1);
      chk("rdFullBubble", Instr_Valid, 0);
      chk("rdFullAddr", BusDirecciones, 32'h804);
      tick(0, 0, 0, 1);
      chk("rdFullValid", Instr_Valid, 1);
      chk("rdFullPc", Instr_PC, 32'h804);
      chk("rdFullData", Instr_Data, 32'h8280_8003);

      // Randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         rr = ($urandom % 60) == 0;
         rv = ($urandom % 12) == 0;
         tg = ($urandom % 4 != 0) ? 32'h800 + ($urandom % 16) : $urandom;
         rd = ($urandom % 10) < 7;
         tick(rr, rv, tg, rd);
      end

      // Wrap-around on a second instance with depth 4
      tick(1, 0, 0, 1);
      chk("wRstAddr", addr2, 32'hFFFF_FFFF);
      chk("wRstValid", valid2, 0);
      rst2 = 1'b0;
      tick(1, 0, 0, 1);
      chk("wPc0", ipc2, 32'hFFFF_FFFF);
      chk("wValid0", valid2, 1);
      tick(1, 0, 0, 1);
      chk("wPc1", ipc2, 32'h0);
      chk("wData1", idata2, memImg(32'h0));
      rst2 = 1'b1;
      tick(1, 0, 0, 1);
      chk("wMidRstValid", valid2, 0);
      chk("wMidRstAddr", addr2, 32'hFFFF_FFFF);
      chk("wMidRstPc", ipc2, 32'h0);
      rst2 = 1'b0; rdy2 = 1'b0;
      for (int k = 0; k < 6; k++) tick(1, 0, 0, 1);
      chk("wFullAddr", addr2, 32'h3);
      chk("wFullHead", ipc2, 32'hFFFF_FFFF);
      rdy2 = 1'b1;
      tick(1, 0, 0, 1);
      chk("wDrainHead", ipc2, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end of the micro datapath. It owns the program counter and drives word addresses onto the program memory's `BusDirecciones`. It captures the combinational `BusDatos` reply together with its PC into a small skid FIFO, then hands instructions to decode over a valid/ready handshake. It supports branch redirect with flush, and stops fetching on the all-zero halt word.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0800: first word address fetched after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Legal values are 2 or 4.

Ports:
- `CLOCK_50`, in, 1: single clock, rising edge.
- `RESET_InHigh`, in, 1: reset, synchronous and active-high.
- `BusDirecciones`, out, 32: word address to program memory, equal to the PC register.
- `BusDatos`, in, 32: instruction word from program memory, valid in the same cycle.
- `Redirect_Valid`, in, 1: one-cycle pulse that redirects fetch.
- `Redirect_Target`, in, 32: new word address, sampled when `Redirect_Valid`=1.
- `Instr_Valid`, out, 1: FIFO head is valid.
- `Instr_Ready`, in, 1: decode accepts the head.
- `Instr_Data`, out, 32: head instruction word.
- `Instr_PC`, out, 32: word address of the head instruction.
- `Halted`, out, 1: halt word captured; fetching stopped.

## Operation
- **Reset**:
  - PC = `RESET_PC`, FIFO empty, `Halted`=0.
  - `Instr_Valid`=0, `Instr_Data`=0, `Instr_PC`=0.
  - `BusDirecciones`=`RESET_PC`.
- **Pop**: occurs when `Instr_Valid & Instr_Ready`.
- **Push condition**: push = !`Halted` & !`Redirect_Valid` & (count < `FIFO_DEPTH` | pop).
- **Push action**: store {PC, `BusDatos`}, then PC <= PC+1. Arithmetic is modulo 2^32, so 32'hFFFF_FFFF wraps to 0.
- **Halt**: when a pushed word equals 32'h0000_0000:
  - The word is still pushed and delivered to decode.
  - `Halted`<=1 and PC holds the halt word's address.
  - No further pushes occur until redirect or reset.
- **Redirect** has top priority:
  - FIFO flushed (count=0); any pop in that cycle is discarded.
  - No push in that cycle.
  - PC <= `Redirect_Target`, `Halted`<=0.
- **Full FIFO with no pop**: PC holds and `BusDirecciones` is stable.
- **FIFO order**: strictly in order. Simultaneous push and pop at full leaves count unchanged.
- **Output registration**: `Instr_Data`/`Instr_PC` come from the registered head entry. They are stable while `Instr_Valid`=1 and `Instr_Ready`=0.

## Timing
- **Address path**: `BusDirecciones` is purely the PC register, with no combinational path from inputs.
- **Fetch latency**: an address issued in cycle N makes its instruction visible at the FIFO head in cycle N+1 if the FIFO was empty.
- **After reset release**: `BusDirecciones`=`RESET_PC` in the first cycle, and `Instr_Valid`=1 in the next.
- **Redirect latency**: redirect asserted in cycle N gives target on `BusDirecciones` in N+1 and the target instruction valid in N+2. The bubble is one cycle minimum.
- **Throughput**: one instruction per cycle with `Instr_Ready` held high.
- **Reset mid-operation**: overrides everything in the same edge; all state returns to reset values.
- **Redirect while halted**: clears `Halted` on the same edge; fetch resumes at the target next cycle.

## Structure
- **Package `fetch_pkg`**:
  - `RESET_PC_DEFAULT` (32'h800), `HALT_WORD` (32'h0).
  - `WORD_W`=32.
  - Typedef `fetch_entry_t` = {pc[31:0], instr[31:0]}.
- **Sub-module `fetch_fifo`**:
  - Parameterised depth with push, pop, flush, count, and head.
  - Synchronous reset; flush has priority over push/pop.
- **`fetch_unit` contents**: PC register, halt flag, push/redirect control.

## Test plan
- **Reset sequence**:
  - Stimulus: release reset with `Instr_Ready`=1 against the standard program memory image.
  - Required response: `Instr_PC`/`Instr_Data` are 0x800/0x82802001, 0x801/0x84802001, 0x802/0x86802000 on consecutive cycles.
- **Backpressure**:
  - Stimulus: hold `Instr_Ready`=0 for 5 cycles after reset.
  - Required response:
    - `BusDirecciones` stops at 0x802 with count=2.
    - Head stays 0x800/0x82802001.
    - On release, words 0x800, 0x801, 0x802 arrive with no loss or duplication.
- **Halt**:
  - Stimulus: run to 0x80E.
  - Required response:
    - Word 0x00000000 is delivered with `Instr_PC`=0x80E.
    - `Halted`=1 the following cycle.
    - `BusDirecciones` holds 0x80E and no further `Instr_Valid` appears.
- **Redirect with full FIFO**:
  - Stimulus: pulse `Redirect_Valid` with target 0x804 while the FIFO is full and `Instr_Ready`=1.
  - Required response:
    - `Instr_Valid`=0 the next cycle.
    - `BusDirecciones`=0x804.
    - Then 0x804/0x82808003 is valid.
- **Redirect while halted**:
  - Stimulus: redirect to 0x800 while halted.
  - Required response: `Halted` clears and the 0x82802001 stream restarts.
- **Wrap and reset**:
  - Stimulus: set `RESET_PC`=32'hFFFF_FFFF and fetch 2 words.
  - Required response: `Instr_PC` sequence is FFFF_FFFF, 0000_0000.
  - Stimulus: assert reset mid-stream.
  - Required response: `Instr_Valid`=0 next cycle.
